parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 The parameter DATA_W SHALL default to 4 and SHALL set the number of data bits per frame.
REQ-002 The parameter ODD SHALL default to 0; 0 SHALL select even parity and 1 SHALL select odd parity.
REQ-003 The parameter CNT_W SHALL default to 8 and SHALL set the width of the error counter.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 rx_bit  input  1  SHALL be the serial line; it is idle high.
REQ-007 rx_en  input  1  SHALL be the bit strobe; rx_bit SHALL be sampled only in cycles where rx_en=1.
REQ-008 clr_cnt  input  1  SHALL be a synchronous clear for err_cnt.
REQ-009 rx_data  output  DATA_W  SHALL carry the last received data word.
REQ-010 rx_valid  output  1  SHALL be a one-cycle pulse that marks a completed frame.
REQ-011 par_err  output  1  SHALL be a one-cycle pulse, coincident with rx_valid, that flags a parity mismatch.
REQ-012 frm_err  output  1  SHALL be a one-cycle pulse that flags a stop bit sampled as 0.
REQ-013 err_cnt  output  CNT_W  SHALL be a saturating count of par_err and frm_err pulses.
REQ-014 busy  output  1  SHALL be 1 whenever the FSM is not in IDLE.

Function
REQ-015 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
REQ-016 The FSM SHALL have exactly four states: IDLE, DATA, PAR, STOP.
REQ-017 In IDLE, a sample with rx_en=1 and rx_bit=0 SHALL move to DATA, clear the bit index, and clear the parity accumulator; a sample of 1 SHALL leave the FSM in IDLE.
REQ-018 In DATA, each sample SHALL shift into the data register LSB first and XOR into the accumulator; after the DATA_W-th sample the FSM SHALL move to PAR.
REQ-019 In PAR, the sample SHALL XOR into the accumulator, and the FSM SHALL move to STOP.
REQ-020 In STOP, a sample of 1 SHALL load rx_data, pulse rx_valid, set par_err = accumulator XOR ODD, and return to IDLE.
REQ-021 In STOP, a sample of 0 SHALL pulse frm_err, leave rx_data and rx_valid unchanged, and return to IDLE.
REQ-022 All outputs SHALL be registered: each pulse SHALL assert in the cycle after the stop-bit sample and last exactly one cycle.
REQ-023 A frame with a parity error SHALL still update rx_data and pulse rx_valid.
REQ-024 Cycles with rx_en=0 SHALL hold all state; gaps of any length between strobes SHALL be legal.
REQ-025 err_cnt SHALL increment by 1 on each par_err or frm_err pulse and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-026 If clr_cnt=1 in the same cycle as an increment, the clear SHALL win and err_cnt SHALL become 0.

Reset
REQ-027 rst=1 SHALL force the FSM to IDLE from any state, abandoning any partial frame.
REQ-028 rst=1 SHALL force rx_data, rx_valid, par_err, frm_err, err_cnt, busy, the bit index and the accumulator to 0.
REQ-029 rst SHALL take priority over rx_en and clr_cnt.

Structure
REQ-030 The state encoding and the default values of DATA_W, ODD and CNT_W SHALL reside in the shared package parity_pkg.
REQ-031 The saturating counter SHALL be a separate sub-module named sat_cnt, with ports clk, rst, inc, clr and cnt.
REQ-032 The FSM, shift register and parity accumulator SHALL reside in parity_rx itself.

Verification
All scenarios use DATA_W=4, ODD=0, CNT_W=8.
REQ-033 Send start 0, data 1,0,1,1, parity 1, stop 1 -> rx_data=0xD, one-cycle rx_valid, par_err=0, err_cnt=0.
REQ-034 Send the REQ-033 frame with parity 0 -> rx_data=0xD, rx_valid=1, par_err=1, err_cnt=1.
REQ-035 Send a valid frame with stop 0 -> frm_err=1, rx_valid=0, rx_data held, err_cnt increments by 1.
REQ-036 Send the REQ-033 frame with 3 idle cycles (rx_en=0) between strobes -> result identical to REQ-033; busy=1 throughout the frame.
REQ-037 Send 260 parity-error frames -> err_cnt=255; then assert clr_cnt in the same cycle as an error pulse -> err_cnt=0.
REQ-038 Assert rst after the 2nd data bit -> busy=0 and all outputs 0 in the next cycle; a following REQ-033 frame -> rx_data=0xD, no errors.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity-checked serial receiver.
// FSM encoding and the default frame/counter geometry live here.
package parity_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ODD_DEF    = 0;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

endpackage

// File: rtl/parity_rx_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/parity_rx.sv
// Strobed serial receiver: start, DATA_W bits LSB first, parity, stop.
// Emits registered one-cycle valid/error pulses and a saturating error count.
module parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ODD    = ODD_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_en,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              par_err,
  output logic              frm_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic        ODD_BIT = 1'(ODD);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [DATA_W-1:0]   shreg, shreg_next;
  logic                acc, acc_next;
  logic [DATA_W-1:0]   data_next;
  logic                valid_next, perr_next, ferr_next;

  // Next-state and next-output logic; every register holds unless strobed.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    acc_next   = acc;
    data_next  = rx_data;
    valid_next = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_bit) begin
            state_next = DATA;
            idx_next   = '0;
            acc_next   = 1'b0;
          end
        end
        DATA: begin
          shreg_next = DATA_W'({rx_bit, shreg} >> 1);
          acc_next   = acc ^ rx_bit;
          idx_next   = idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_next = PAR;
          end
        end
        PAR: begin
          acc_next   = acc ^ rx_bit;
          state_next = STOP;
        end
        STOP: begin
          if (rx_bit) begin
            data_next  = shreg;
            valid_next = 1'b1;
            perr_next  = acc ^ ODD_BIT;
          end else begin
            ferr_next  = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      shreg    <= '0;
      acc      <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      shreg    <= shreg_next;
      acc      <= acc_next;
      rx_data  <= data_next;
      rx_valid <= valid_next;
      par_err  <= perr_next;
      frm_err  <= ferr_next;
      busy     <= (state_next != IDLE);
    end
  end

  // Counts the registered error pulses, so err_cnt moves one cycle after them.
  sat_cnt #(
    .W (CNT_W)
  ) u_sat_cnt (
    .clk (clk),
    .rst (rst),
    .inc (par_err | frm_err),
    .clr (clr_cnt),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_parity_rx.sv
// Randomized bench for parity_rx against a frame-level reference model.
module tb_parity_rx;
  import parity_pkg::*;

  localparam int unsigned DW      = 4;
  localparam int unsigned CW      = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_bit;
  logic          rx_en;
  logic          clr_cnt;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          par_err;
  logic          frm_err;
  logic [CW-1:0] err_cnt;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            mdl_cnt;
  logic [DW-1:0] mdl_data;

  parity_rx #(
    .DATA_W (DW),
    .ODD    (0),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_bit   (rx_bit),
    .rx_en    (rx_en),
    .clr_cnt  (clr_cnt),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One strobed non-stop bit, then gap idle cycles; busy expected throughout.
  task automatic strobe(input logic b, input int gap, input logic busy_exp);
    rx_en  = 1'b1;
    rx_bit = b;
    @(negedge clk);
    rx_en  = 1'b0;
    rx_bit = 1'b1;
    check("busy", 32'(busy), 32'(busy_exp));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("busy_gap", 32'(busy), 32'(busy_exp));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                            input int gap, input logic clr_at_pulse);
    logic exp_perr;
    logic err;
    exp_perr = ((($countones(d) + int'(p)) % 2) != int'(ODD_DEF));
    strobe(1'b0, gap, 1'b1);
    for (int i = 0; i < int'(DW); i++) strobe(d[i], gap, 1'b1);
    strobe(p, gap, 1'b1);
    rx_en  = 1'b1;
    rx_bit = s;
    @(negedge clk);
    rx_en  = 1'b0;
    rx_bit = 1'b1;
    if (s) mdl_data = d;
    check("rx_valid", 32'(rx_valid), 32'(s));
    check("par_err", 32'(par_err), s ? 32'(exp_perr) : 32'd0);
    check("frm_err", 32'(frm_err), 32'(!s));
    check("rx_data", 32'(rx_data), 32'(mdl_data));
    check("busy_end", 32'(busy), 32'd0);
    err = s ? exp_perr : 1'b1;
    if (clr_at_pulse) begin
      clr_cnt = 1'b1;
      mdl_cnt = 0;
    end else if (err && mdl_cnt < CNT_MAX) begin
      mdl_cnt++;
    end
    @(negedge clk);
    clr_cnt = 1'b0;
    check("valid_1cyc", 32'(rx_valid), 32'd0);
    check("perr_1cyc", 32'(par_err), 32'd0);
    check("ferr_1cyc", 32'(frm_err), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_perr"}, 32'(par_err), 32'd0);
    check({tag, "_ferr"}, 32'(frm_err), 32'd0);
    check({tag, "_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_en    = 1'b0;
    rx_bit   = 1'b1;
    clr_cnt  = 1'b0;
    mdl_cnt  = 0;
    mdl_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Idle-high sample must not start a frame.
    strobe(1'b1, 0, 1'b0);

    send_frame(4'hD, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'hD, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'h6, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'hD, 1'b1, 1'b1, 3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      send_frame(DW'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 2)), 1'b0);
    end

    for (int n = 0; n < 260; n++) send_frame(4'hD, 1'b0, 1'b1, 0, 1'b0);
    check("cnt_saturated", 32'(err_cnt), 32'(CNT_MAX));
    send_frame(4'hD, 1'b0, 1'b1, 0, 1'b1);
    check("cnt_clr_wins", 32'(err_cnt), 32'd0);

    send_frame(4'hA, 1'b1, 1'b1, 1, 1'b0);
    strobe(1'b0, 0, 1'b1);
    strobe(1'b1, 0, 1'b1);
    strobe(1'b0, 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst      = 1'b0;
    mdl_cnt  = 0;
    mdl_data = '0;
    send_frame(4'hD, 1'b1, 1'b1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
